// File: rtl/srv1_pkg.sv
// Shared SRV1 pipeline encodings: controller state, register constants, stage control bundle.
package srv1_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    REDIRECT = 2'd2
  } pipe_state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic fetch_en;
    logic decode_en;
    logic execute_en;
    logic memory_en;
    logic writeback_en;
    logic decode_flush;
    logic execute_flush;
  } stage_ctrl_t;

  localparam stage_ctrl_t CTRL_IDLE = '{
    fetch_en: 1'b0, decode_en: 1'b0, execute_en: 1'b0, memory_en: 1'b0,
    writeback_en: 1'b0, decode_flush: 1'b0, execute_flush: 1'b0};

  localparam stage_ctrl_t CTRL_RESET = '{
    fetch_en: 1'b0, decode_en: 1'b0, execute_en: 1'b0, memory_en: 1'b0,
    writeback_en: 1'b0, decode_flush: 1'b1, execute_flush: 1'b1};

  localparam stage_ctrl_t CTRL_RUN = '{
    fetch_en: 1'b1, decode_en: 1'b1, execute_en: 1'b1, memory_en: 1'b1,
    writeback_en: 1'b1, decode_flush: 1'b0, execute_flush: 1'b0};

endpackage

// File: rtl/hazard_detect.sv
// Read-after-write detection between execute sources and memory/writeback destinations.
module hazard_detect
  import srv1_pkg::*;
(
  input  logic [4:0] exe_rs1_address,
  input  logic [4:0] exe_rs2_address,
  input  logic       exe_uses_rs1,
  input  logic       exe_uses_rs2,
  input  logic [4:0] mem_rd_address,
  input  logic       mem_writes_rd,
  input  logic [4:0] wb_rd_address,
  input  logic       wb_writes_rd,
  output logic       raw
);

  logic rs1_hit;
  logic rs2_hit;

  // No forwarding exists, so any live producer of a read source stalls; x0 is never produced.
  always_comb begin
    rs1_hit = exe_uses_rs1 && (exe_rs1_address != REG_X0) &&
              ((mem_writes_rd && (mem_rd_address == exe_rs1_address)) ||
               (wb_writes_rd  && (wb_rd_address  == exe_rs1_address)));
    rs2_hit = exe_uses_rs2 && (exe_rs2_address != REG_X0) &&
              ((mem_writes_rd && (mem_rd_address == exe_rs2_address)) ||
               (wb_writes_rd  && (wb_rd_address  == exe_rs2_address)));
    raw     = rs1_hit || rs2_hit;
  end

endmodule

// File: rtl/pipeline_controller.sv
// Five-stage pipeline sequencer: stage enables, flushes, redirect bubbles and stall/flush counters.
module pipeline_controller
  import srv1_pkg::*;
#(
  parameter int unsigned FETCH_LATENCY = 1,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             async_rst,
  input  logic             clk_en,
  input  logic [4:0]       exe_rs1_address,
  input  logic [4:0]       exe_rs2_address,
  input  logic             exe_uses_rs1,
  input  logic             exe_uses_rs2,
  input  logic             pc_jmp,
  input  logic [4:0]       mem_rd_address,
  input  logic             mem_writes_rd,
  input  logic [4:0]       wb_rd_address,
  input  logic             wb_writes_rd,
  input  logic             mem_busy,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             execute_en,
  output logic             memory_en,
  output logic             writeback_en,
  output logic             decode_flush,
  output logic             execute_flush,
  output logic             pc_load,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned RC_W = (FETCH_LATENCY > 0) ? $clog2(FETCH_LATENCY + 1) : 1;

  pipe_state_t     state, state_nxt;
  logic [RC_W-1:0] redir_cnt, redir_nxt;
  stage_ctrl_t     ctrl;
  logic            raw;
  logic            stall_inc;
  logic            flush_inc;

  hazard_detect u_hazard (
    .exe_rs1_address (exe_rs1_address),
    .exe_rs2_address (exe_rs2_address),
    .exe_uses_rs1    (exe_uses_rs1),
    .exe_uses_rs2    (exe_uses_rs2),
    .mem_rd_address  (mem_rd_address),
    .mem_writes_rd   (mem_writes_rd),
    .wb_rd_address   (wb_rd_address),
    .wb_writes_rd    (wb_writes_rd),
    .raw             (raw)
  );

  // Next-state and stage controls; MEM_WAIT re-evaluates like RUN as soon as the bus frees.
  always_comb begin
    ctrl      = CTRL_IDLE;
    pc_load   = 1'b0;
    state_nxt = state;
    redir_nxt = redir_cnt;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    if (async_rst) begin
      ctrl = CTRL_RESET;
    end else if (clk_en) begin
      case (state)
        RUN, MEM_WAIT: begin
          if (mem_busy) begin
            state_nxt = MEM_WAIT;
            stall_inc = 1'b1;
          end else if (raw) begin
            ctrl.memory_en     = 1'b1;
            ctrl.writeback_en  = 1'b1;
            ctrl.execute_flush = 1'b1;
            state_nxt          = RUN;
            stall_inc          = 1'b1;
          end else if (pc_jmp) begin
            ctrl               = CTRL_RUN;
            ctrl.decode_flush  = 1'b1;
            ctrl.execute_flush = 1'b1;
            pc_load            = 1'b1;
            flush_inc          = 1'b1;
            if (FETCH_LATENCY > 0) begin
              state_nxt = REDIRECT;
              redir_nxt = RC_W'(FETCH_LATENCY);
            end else begin
              state_nxt = RUN;
            end
          end else begin
            ctrl      = CTRL_RUN;
            state_nxt = RUN;
          end
        end
        REDIRECT: begin
          if (mem_busy) begin
            stall_inc = 1'b1;
          end else begin
            ctrl              = CTRL_RUN;
            ctrl.decode_flush = 1'b1;
            if (redir_cnt <= RC_W'(1)) begin
              state_nxt = RUN;
              redir_nxt = '0;
            end else begin
              redir_nxt = redir_cnt - RC_W'(1);
            end
          end
        end
        default: begin
          state_nxt = RUN;
          redir_nxt = '0;
        end
      endcase
    end
  end

  assign fetch_en      = ctrl.fetch_en;
  assign decode_en     = ctrl.decode_en;
  assign execute_en    = ctrl.execute_en;
  assign memory_en     = ctrl.memory_en;
  assign writeback_en  = ctrl.writeback_en;
  assign decode_flush  = ctrl.decode_flush;
  assign execute_flush = ctrl.execute_flush;

  // State, bubble counter and saturating performance counters.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      state       <= RUN;
      redir_cnt   <= '0;
      stall_count <= '0;
      flush_count <= '0;
    end else if (clk_en) begin
      state     <= state_nxt;
      redir_cnt <= redir_nxt;
      if (stall_inc && (stall_count != {CNT_W{1'b1}})) begin
        stall_count <= stall_count + CNT_W'(1);
      end
      if (flush_inc && (flush_count != {CNT_W{1'b1}})) begin
        flush_count <= flush_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_controller.sv
// Randomized and directed bench for pipeline_controller against a bubble-count reference model.
module tb_pipeline_controller;

  localparam int unsigned FL_A = 1;
  localparam int unsigned W_A  = 4;
  localparam int unsigned FL_B = 3;
  localparam int unsigned W_B  = 16;

  logic clk = 1'b0;
  logic async_rst, clk_en;
  logic [4:0] rs1, rs2, mrd, wrd;
  logic u1, u2, mw, ww, jmp, busy;
  logic [7:0] out_a, out_b;
  logic [W_A-1:0] sc_a, fc_a;
  logic [W_B-1:0] sc_b, fc_b;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: remaining decode bubbles after a redirect, plus counters.
  int fl[2]  = '{FL_A, FL_B};
  int mx[2]  = '{(1 << W_A) - 1, (1 << W_B) - 1};
  int bub[2] = '{0, 0};
  int sc[2]  = '{0, 0};
  int fc[2]  = '{0, 0};

  always #5 clk = ~clk;

  pipeline_controller #(.FETCH_LATENCY(FL_A), .CNT_W(W_A)) dut_a (
    .clk(clk), .async_rst(async_rst), .clk_en(clk_en),
    .exe_rs1_address(rs1), .exe_rs2_address(rs2),
    .exe_uses_rs1(u1), .exe_uses_rs2(u2), .pc_jmp(jmp),
    .mem_rd_address(mrd), .mem_writes_rd(mw),
    .wb_rd_address(wrd), .wb_writes_rd(ww), .mem_busy(busy),
    .fetch_en(out_a[7]), .decode_en(out_a[6]), .execute_en(out_a[5]),
    .memory_en(out_a[4]), .writeback_en(out_a[3]),
    .decode_flush(out_a[2]), .execute_flush(out_a[1]), .pc_load(out_a[0]),
    .stall_count(sc_a), .flush_count(fc_a)
  );

  pipeline_controller #(.FETCH_LATENCY(FL_B), .CNT_W(W_B)) dut_b (
    .clk(clk), .async_rst(async_rst), .clk_en(clk_en),
    .exe_rs1_address(rs1), .exe_rs2_address(rs2),
    .exe_uses_rs1(u1), .exe_uses_rs2(u2), .pc_jmp(jmp),
    .mem_rd_address(mrd), .mem_writes_rd(mw),
    .wb_rd_address(wrd), .wb_writes_rd(ww), .mem_busy(busy),
    .fetch_en(out_b[7]), .decode_en(out_b[6]), .execute_en(out_b[5]),
    .memory_en(out_b[4]), .writeback_en(out_b[3]),
    .decode_flush(out_b[2]), .execute_flush(out_b[1]), .pc_load(out_b[0]),
    .stall_count(sc_b), .flush_count(fc_b)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic src_hit(input logic [4:0] a, input logic uses);
    return uses && (a != 5'd0) && ((mw && mrd == a) || (ww && wrd == a));
  endfunction

  // Expected {fetch,decode,execute,memory,wb,dflush,eflush,pc_load} for instance i.
  function automatic logic [7:0] expect_out(input int i);
    if (async_rst) return 8'b0000_0110;
    if (!clk_en || busy) return 8'b0000_0000;
    if (bub[i] > 0) return 8'b1111_1100;
    if (src_hit(rs1, u1) || src_hit(rs2, u2)) return 8'b0001_1010;
    if (jmp) return 8'b1111_1111;
    return 8'b1111_1000;
  endfunction

  function automatic int sat_inc(input int v, input int lim);
    return (v < lim) ? v + 1 : v;
  endfunction

  task automatic step_model(input int i);
    if (!clk_en) return;
    if (busy) begin
      sc[i] = sat_inc(sc[i], mx[i]);
    end else if (bub[i] > 0) begin
      bub[i]--;
    end else if (src_hit(rs1, u1) || src_hit(rs2, u2)) begin
      sc[i] = sat_inc(sc[i], mx[i]);
    end else if (jmp) begin
      fc[i]  = sat_inc(fc[i], mx[i]);
      bub[i] = fl[i];
    end
  endtask

  // Inputs are set just after a negedge; check #1 later, advance the model, move to next negedge.
  task automatic run_cycle(input string tag);
    #1;
    if (async_rst) begin
      for (int i = 0; i < 2; i++) begin
        bub[i] = 0; sc[i] = 0; fc[i] = 0;
      end
    end
    check({tag, ".out_a"}, int'(out_a), int'(expect_out(0)));
    check({tag, ".out_b"}, int'(out_b), int'(expect_out(1)));
    check({tag, ".stall_a"}, int'(sc_a), sc[0]);
    check({tag, ".stall_b"}, int'(sc_b), sc[1]);
    check({tag, ".flush_a"}, int'(fc_a), fc[0]);
    check({tag, ".flush_b"}, int'(fc_b), fc[1]);
    if (!async_rst) begin
      step_model(0);
      step_model(1);
    end
    @(negedge clk);
  endtask

  task automatic quiet();
    async_rst = 1'b0; clk_en = 1'b1;
    rs1 = 5'd0; rs2 = 5'd0; u1 = 1'b0; u2 = 1'b0;
    mrd = 5'd0; wrd = 5'd0; mw = 1'b0; ww = 1'b0;
    jmp = 1'b0; busy = 1'b0;
  endtask

  initial begin
    quiet();
    async_rst = 1'b1;
    clk_en    = 1'b0;
    @(negedge clk);
    run_cycle("reset");
    quiet();

    // Independent operations.
    rs1 = 5'd4; rs2 = 5'd5; u1 = 1'b1; u2 = 1'b1;
    mrd = 5'd2; mw = 1'b1; wrd = 5'd1; ww = 1'b1;
    for (int k = 0; k < 3; k++) run_cycle("indep");
    check("indep_stall", int'(sc_a), 0);

    // RAW on rs1 from memory, then from writeback.
    quiet();
    rs1 = 5'd5; u1 = 1'b1; mrd = 5'd5; mw = 1'b1;
    run_cycle("raw_mem");
    mw = 1'b0; wrd = 5'd5; ww = 1'b1;
    run_cycle("raw_wb");
    ww = 1'b0;
    run_cycle("raw_done");
    check("raw_stall_total", int'(sc_a), 2);

    // x0 never stalls.
    quiet();
    rs1 = 5'd0; u1 = 1'b1; mrd = 5'd0; mw = 1'b1;
    run_cycle("x0");

    // Taken jump and its bubbles.
    quiet();
    jmp = 1'b1;
    run_cycle("jmp");
    jmp = 1'b0;
    for (int k = 0; k < 4; k++) run_cycle("jmp_bub");
    check("jmp_flush_total", int'(fc_a), 1);

    // Jump held during memory wait resolves once the bus frees.
    busy = 1'b1; jmp = 1'b1;
    for (int k = 0; k < 3; k++) run_cycle("jmp_busy");
    busy = 1'b0;
    run_cycle("jmp_after_busy");
    jmp = 1'b0;
    for (int k = 0; k < 4; k++) run_cycle("jmp_busy_bub");
    check("busy_stall_total", int'(sc_a), 5);

    // Busy frozen redirect, then reset mid-redirect.
    jmp = 1'b1;
    run_cycle("redir_start");
    jmp = 1'b0; busy = 1'b1;
    run_cycle("redir_frozen");
    busy = 1'b0;
    run_cycle("redir_go");
    async_rst = 1'b1;
    run_cycle("redir_reset");
    async_rst = 1'b0;
    for (int k = 0; k < 2; k++) run_cycle("post_reset");

    // Saturation of the narrow counter.
    busy = 1'b1;
    for (int k = 0; k < 20; k++) run_cycle("sat");
    check("sat_stall_a", int'(sc_a), 15);

    // Global enable low holds everything.
    clk_en = 1'b0; jmp = 1'b1;
    for (int k = 0; k < 3; k++) run_cycle("clk_en_low");
    quiet();

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      async_rst = ($urandom_range(0, 99) == 0);
      clk_en    = ($urandom_range(0, 9) != 0);
      busy      = ($urandom_range(0, 5) == 0);
      jmp       = ($urandom_range(0, 4) == 0);
      rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3));
      mrd = 5'($urandom_range(0, 3)); wrd = 5'($urandom_range(0, 3));
      u1 = 1'($urandom_range(0, 1)); u2 = 1'($urandom_range(0, 1));
      mw = ($urandom_range(0, 2) == 0); ww = ($urandom_range(0, 2) == 0);
      run_cycle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
